// File: rtl/sunsen_frame_rx.sv
// Sun-sensor frame receiver: assembles 7-byte SYNC/STATUS/X/Y/CHK frames from
// the I2C sequencer byte strobe, checks the XOR checksum and publishes good frames.
module sunsen_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE   = 8'h5A,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_ack,
    output logic        frame_ready,
    output logic [7:0]  sen_status,
    output logic [15:0] x_angle,
    output logic [15:0] y_angle,
    output logic [7:0]  chk_err_cnt,
    output logic [7:0]  timeout_cnt,
    output logic [7:0]  overrun_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {HUNT, RECV, CHECK} state_t;

    localparam logic [15:0] GAP_MAX = TIMEOUT_CYC - 16'd1;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [15:0] gap_q, gap_d;
    logic        chk_ok_q, chk_ok_d;
    logic [7:0]  sh_status_q, sh_status_d;
    logic [15:0] sh_x_q, sh_x_d;
    logic [15:0] sh_y_q, sh_y_d;

    logic        frame_ready_q, frame_ready_d;
    logic [7:0]  sen_status_q, sen_status_d;
    logic [15:0] x_angle_q, x_angle_d;
    logic [15:0] y_angle_q, y_angle_d;
    logic [7:0]  chk_err_cnt_q, chk_err_cnt_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;
    logic [7:0]  overrun_cnt_q, overrun_cnt_d;
    logic        busy_q, busy_d;

    logic        sync_seen;
    assign sync_seen = rx_valid && (rx_data == SYNC_BYTE);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xor_d         = xor_q;
        gap_d         = gap_q;
        chk_ok_d      = chk_ok_q;
        sh_status_d   = sh_status_q;
        sh_x_d        = sh_x_q;
        sh_y_d        = sh_y_q;
        sen_status_d  = sen_status_q;
        x_angle_d     = x_angle_q;
        y_angle_d     = y_angle_q;
        chk_err_cnt_d = chk_err_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        // An ack clears the flag; a commit in the same cycle overrides below.
        frame_ready_d = frame_ready_q && !frame_ack;

        case (state_q)
            HUNT: begin
                if (sync_seen) begin
                    state_d = RECV;
                    idx_d   = 3'd1;
                    xor_d   = 8'h00;
                    gap_d   = 16'd0;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (idx_q == 3'd6) begin
                        chk_ok_d = (rx_data == xor_q);
                        state_d  = CHECK;
                    end else begin
                        case (idx_q)
                            3'd1:    sh_status_d   = rx_data;
                            3'd2:    sh_x_d[15:8]  = rx_data;
                            3'd3:    sh_x_d[7:0]   = rx_data;
                            3'd4:    sh_y_d[15:8]  = rx_data;
                            default: sh_y_d[7:0]   = rx_data;
                        endcase
                        xor_d = xor_q ^ rx_data;
                        idx_d = idx_q + 3'd1;
                    end
                    gap_d = 16'd0;
                end else if (gap_q == GAP_MAX) begin
                    state_d       = HUNT;
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            CHECK: begin
                if (chk_ok_q) begin
                    sen_status_d  = sh_status_q;
                    x_angle_d     = sh_x_q;
                    y_angle_d     = sh_y_q;
                    frame_ready_d = 1'b1;
                    if (frame_ready_q && !frame_ack)
                        overrun_cnt_d = sat_inc(overrun_cnt_q);
                end else begin
                    chk_err_cnt_d = sat_inc(chk_err_cnt_q);
                end
                // A SYNC arriving in this cycle starts the next frame directly.
                if (sync_seen) begin
                    state_d = RECV;
                    idx_d   = 3'd1;
                    xor_d   = 8'h00;
                    gap_d   = 16'd0;
                end else begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= HUNT;
            idx_q         <= 3'd0;
            xor_q         <= 8'h00;
            gap_q         <= 16'd0;
            chk_ok_q      <= 1'b0;
            sh_status_q   <= 8'h00;
            sh_x_q        <= 16'h0000;
            sh_y_q        <= 16'h0000;
            frame_ready_q <= 1'b0;
            sen_status_q  <= 8'h00;
            x_angle_q     <= 16'h0000;
            y_angle_q     <= 16'h0000;
            chk_err_cnt_q <= 8'h00;
            timeout_cnt_q <= 8'h00;
            overrun_cnt_q <= 8'h00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            gap_q         <= gap_d;
            chk_ok_q      <= chk_ok_d;
            sh_status_q   <= sh_status_d;
            sh_x_q        <= sh_x_d;
            sh_y_q        <= sh_y_d;
            frame_ready_q <= frame_ready_d;
            sen_status_q  <= sen_status_d;
            x_angle_q     <= x_angle_d;
            y_angle_q     <= y_angle_d;
            chk_err_cnt_q <= chk_err_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            busy_q        <= busy_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign sen_status  = sen_status_q;
    assign x_angle     = x_angle_q;
    assign y_angle     = y_angle_q;
    assign chk_err_cnt = chk_err_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sunsen_frame_rx.sv
// Directed bench for sunsen_frame_rx: frames, checksum errors, timeout,
// overrun/ack race, hunt/back-to-back, async reset and counter saturation.
module tb_sunsen_frame_rx;

    localparam logic [15:0] TO = 16'd100;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        frame_ack = 1'b0;
    logic        frame_ready;
    logic [7:0]  sen_status;
    logic [15:0] x_angle;
    logic [15:0] y_angle;
    logic [7:0]  chk_err_cnt;
    logic [7:0]  timeout_cnt;
    logic [7:0]  overrun_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sunsen_frame_rx #(.SYNC_BYTE(8'h5A), .TIMEOUT_CYC(TO)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_ack(frame_ack), .frame_ready(frame_ready), .sen_status(sen_status),
        .x_angle(x_angle), .y_angle(y_angle), .chk_err_cnt(chk_err_cnt),
        .timeout_cnt(timeout_cnt), .overrun_cnt(overrun_cnt), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every step leaves time at 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        idle(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [15:0] x,
                              input logic [15:0] y, input logic [7:0] c);
        send(8'h5A); send(s); send(x[15:8]); send(x[7:0]);
        send(y[15:8]); send(y[7:0]); send(c);
    endtask

    task automatic ack;
        frame_ack = 1'b1;
        idle(1);
        frame_ack = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_ready", frame_ready, 0);
        chk("rst_outs", {sen_status, x_angle}, 0);
        chk("rst_cnts", {chk_err_cnt, timeout_cnt, overrun_cnt, 7'd0, busy}, 0);
        PRESETN = 1'b1;
        idle(2);

        // 1: good frame, latency CHK+2
        send_frame(8'h01, 16'h1234, 16'h5678, 8'h09);
        chk("t1_not_yet", frame_ready, 0);
        chk("t1_busy_check", busy, 1);
        idle(1);
        chk("t1_ready", frame_ready, 1);
        chk("t1_status", sen_status, 8'h01);
        chk("t1_x", x_angle, 16'h1234);
        chk("t1_y", y_angle, 16'h5678);
        chk("t1_cnts", {chk_err_cnt, timeout_cnt, overrun_cnt}, 0);
        chk("t1_busy", busy, 0);
        ack();
        chk("t1_acked", frame_ready, 0);
        ack();
        chk("t1_ack_idle", frame_ready, 0);

        // 2: bad checksum
        send_frame(8'h01, 16'h1234, 16'h5678, 8'h0A);
        idle(1);
        chk("t2_ready", frame_ready, 0);
        chk("t2_x_kept", x_angle, 16'h1234);
        chk("t2_chkerr", chk_err_cnt, 1);
        chk("t2_busy", busy, 0);

        // 3: inter-byte timeout
        send(8'h5A); send(8'h01); send(8'h12);
        idle(int'(TO) - 1);
        chk("t3_pre_to_busy", busy, 1);
        chk("t3_pre_to_cnt", timeout_cnt, 0);
        idle(1);
        chk("t3_to_cnt", timeout_cnt, 1);
        chk("t3_hunt", busy, 0);
        send_frame(8'h02, 16'h1122, 16'h3344, 8'h46);
        idle(1);
        chk("t3_ready", frame_ready, 1);
        chk("t3_status", sen_status, 8'h02);
        chk("t3_x", x_angle, 16'h1122);
        chk("t3_y", y_angle, 16'h3344);
        ack();

        // 4: overrun, then ack in commit cycle
        send_frame(8'h01, 16'h1234, 16'h5678, 8'h09);
        idle(1);
        send_frame(8'h01, 16'hABCD, 16'h5678, 8'h49);
        idle(1);
        chk("t4_x", x_angle, 16'hABCD);
        chk("t4_ovr", overrun_cnt, 1);
        chk("t4_ready", frame_ready, 1);
        send_frame(8'h03, 16'h0000, 16'h0000, 8'h03);
        ack();
        chk("t4_race_ready", frame_ready, 1);
        chk("t4_race_ovr", overrun_cnt, 1);
        chk("t4_race_status", sen_status, 8'h03);
        ack();

        // 5: garbage dropped, back-to-back frames, mid-frame SYNC as data
        send(8'h00); send(8'hFF); send(8'h33);
        chk("t5_garbage_busy", busy, 0);
        send_frame(8'h04, 16'h0102, 16'h0304, 8'h00);
        send(8'h5A);
        chk("t5_b2b_status", sen_status, 8'h04);
        chk("t5_b2b_busy", busy, 1);
        send(8'h05); send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h45);
        idle(1);
        chk("t5_second_x", x_angle, 16'h1020);
        chk("t5_second_y", y_angle, 16'h3040);
        chk("t5_ovr", overrun_cnt, 2);
        ack();
        send_frame(8'h5A, 16'h0102, 16'h0304, 8'h5E);
        idle(1);
        chk("t5_syncdata_status", sen_status, 8'h5A);
        chk("t5_syncdata_ready", frame_ready, 1);
        chk("t5_chkerr", chk_err_cnt, 1);

        // 6: async reset mid-frame, then checksum-error saturation
        send(8'h5A); send(8'h06); send(8'h07);
        PRESETN = 1'b0;
        #1;
        chk("t6_rst_ready", frame_ready, 0);
        chk("t6_rst_outs", {sen_status, x_angle, 8'h00} | {16'h0, y_angle}, 0);
        chk("t6_rst_cnts", {chk_err_cnt, timeout_cnt, overrun_cnt, 7'd0, busy}, 0);
        #2;
        PRESETN = 1'b1;
        idle(1);
        send(8'h08); send(8'h09); send(8'h0A); send(8'h0B);
        idle(1);
        chk("t6_tail_dropped", {7'd0, busy, 7'd0, frame_ready, chk_err_cnt}, 0);
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h00, 16'h0000, 16'h0000, 8'h01);
            idle(1);
        end
        chk("t6_sat", chk_err_cnt, 8'hFF);
        chk("t6_sat_ready", frame_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
